// File: rtl/alu_ram_datapath.sv
// ALU with operand/write-back muxes plus a single-port RAM with a one-cycle registered read.
// Optional registered zero/carry flags are built only when ALU_RAM_DATAPATH_FLAGS_EN is defined.
module alu_ram_datapath #(
    parameter int DATA_BITS     = 8,
    parameter int ADDR_BITS     = 8,
    parameter int MEM_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_sel,
    input  logic [DATA_BITS-1:0]     a_reg,
    input  logic [DATA_BITS-1:0]     a_imm,
    input  logic [DATA_BITS-1:0]     b,
    input  logic                     sub,
    input  logic                     wb_sel,
    output logic [DATA_BITS-1:0]     result,
    output logic                     cout,
    output logic [DATA_BITS-1:0]     wb_data,
    input  logic [ADDR_BITS-1:0]     mem_addr,
    input  logic                     mem_rd_en,
    input  logic                     mem_wr_en,
    input  logic [MEM_DATA_BITS-1:0] mem_wdata,
    output logic [MEM_DATA_BITS-1:0] mem_rdata,
    output logic                     mem_rvalid,
    output logic                     zero_flag,
    output logic                     carry_flag
);

    logic [DATA_BITS-1:0]     op_a;
    logic [DATA_BITS-1:0]     op_b;
    logic [DATA_BITS:0]       sum;
    logic [MEM_DATA_BITS-1:0] mem [2**ADDR_BITS];
    logic [MEM_DATA_BITS-1:0] rdata_p1;
    logic                     vld_p1;

    // Subtract is A + ~B + 1, so sub doubles as the carry-in.
    always_comb begin
        op_a = a_sel ? a_imm : a_reg;
        op_b = sub ? ~b : b;
        sum  = {1'b0, op_a} + {1'b0, op_b} + {{DATA_BITS{1'b0}}, sub};
    end

    assign result  = sum[DATA_BITS-1:0];
    assign cout    = sum[DATA_BITS];
    assign wb_data = wb_sel ? a_imm : result;

    // Storage is never cleared; only writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!reset && mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Stage p1: registered read; old contents win on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= mem_rd_en;
            if (mem_rd_en) begin
                rdata_p1 <= mem[mem_addr];
            end
        end
    end

    assign mem_rdata  = rdata_p1;
    assign mem_rvalid = vld_p1;

`ifdef ALU_RAM_DATAPATH_FLAGS_EN
    logic zero_p1;
    logic carry_p1;

    // Stage p1: flags capture the ALU outcome of the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_p1  <= 1'b0;
            carry_p1 <= 1'b0;
        end else begin
            zero_p1  <= (result == '0);
            carry_p1 <= cout;
        end
    end

    assign zero_flag  = zero_p1;
    assign carry_flag = carry_p1;
`else
    assign zero_flag  = 1'b0;
    assign carry_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ram_datapath.sv
// Randomized and directed bench for alu_ram_datapath against an arithmetic/array reference model.
module tb_alu_ram_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_sel;
    logic [7:0] a_reg;
    logic [7:0] a_imm;
    logic [7:0] b;
    logic       sub;
    logic       wb_sel;
    logic [7:0] result;
    logic       cout;
    logic [7:0] wb_data;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_rvalid;
    logic       zero_flag;
    logic       carry_flag;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem_m [256];
    logic [7:0] e_rdata = 8'h00;
    logic       e_rvalid = 1'b0;
    logic       e_zf = 1'b0;
    logic       e_cf = 1'b0;

    always #5 clk = ~clk;

    alu_ram_datapath #(
        .DATA_BITS    (8),
        .ADDR_BITS    (8),
        .MEM_DATA_BITS(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_sel     (a_sel),
        .a_reg     (a_reg),
        .a_imm     (a_imm),
        .b         (b),
        .sub       (sub),
        .wb_sel    (wb_sel),
        .result    (result),
        .cout      (cout),
        .wb_data   (wb_data),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain unsigned arithmetic: add wraps at 256, subtract sets carry when no borrow.
    task automatic alu_ref(output logic [7:0] r, output logic c);
        int av;
        int bv;
        av = a_sel ? int'(a_imm) : int'(a_reg);
        bv = int'(b);
        if (sub) begin
            r = 8'((av - bv + 256) % 256);
            c = (av >= bv);
        end else begin
            r = 8'((av + bv) % 256);
            c = ((av + bv) > 255);
        end
    endtask

    task automatic cyc();
        logic [7:0] er;
        logic       ec;
        @(negedge clk);
        alu_ref(er, ec);
        chk("result", 32'(result), 32'(er));
        chk("cout", 32'(cout), 32'(ec));
        chk("wb_data", 32'(wb_data), wb_sel ? 32'(a_imm) : 32'(er));
        @(posedge clk);
        if (reset) begin
            e_rdata  = 8'h00;
            e_rvalid = 1'b0;
            e_zf     = 1'b0;
            e_cf     = 1'b0;
        end else begin
            e_rvalid = mem_rd_en;
            if (mem_rd_en) e_rdata = mem_m[mem_addr];
            if (mem_wr_en) mem_m[mem_addr] = mem_wdata;
`ifdef ALU_RAM_DATAPATH_FLAGS_EN
            e_zf = (er == 8'h00);
            e_cf = ec;
`endif
        end
        #1;
        chk("mem_rdata", 32'(mem_rdata), 32'(e_rdata));
        chk("mem_rvalid", 32'(mem_rvalid), 32'(e_rvalid));
        chk("zero_flag", 32'(zero_flag), 32'(e_zf));
        chk("carry_flag", 32'(carry_flag), 32'(e_cf));
    endtask

    initial begin
        reset = 1'b1; a_sel = 1'b0; a_reg = 8'h00; a_imm = 8'h00; b = 8'h00;
        sub = 1'b0; wb_sel = 1'b0; mem_addr = 8'h00; mem_rd_en = 1'b0;
        mem_wr_en = 1'b0; mem_wdata = 8'h00;
        cyc();
        cyc();
        chk("rst_rdata", 32'(mem_rdata), 32'h0);
        chk("rst_rvalid", 32'(mem_rvalid), 32'h0);
        reset = 1'b0;

        // Give every word a known value so random reads are fully predictable.
        for (int i = 0; i < 256; i++) begin
            mem_wr_en = 1'b1;
            mem_addr  = 8'(i);
            mem_wdata = 8'($urandom);
            cyc();
        end
        mem_wr_en = 1'b0;

        a_sel = 1'b0; a_reg = 8'h05; b = 8'h03; sub = 1'b0; #1;
        chk("add_5_3", 32'(result), 32'h08);
        chk("add_5_3_cout", 32'(cout), 32'h0);
        sub = 1'b1; #1;
        chk("sub_5_3", 32'(result), 32'h02);
        chk("sub_5_3_cout", 32'(cout), 32'h1);
        cyc();

        a_sel = 1'b1; a_imm = 8'hFF; b = 8'h01; sub = 1'b0; #1;
        chk("add_ff_1", 32'(result), 32'h00);
        chk("add_ff_1_cout", 32'(cout), 32'h1);
        cyc();
`ifdef ALU_RAM_DATAPATH_FLAGS_EN
        chk("zf_wrap", 32'(zero_flag), 32'h1);
        chk("cf_wrap", 32'(carry_flag), 32'h1);
`endif

        a_sel = 1'b0; a_reg = 8'h03; b = 8'h05; sub = 1'b1; wb_sel = 1'b1; a_imm = 8'h42; #1;
        chk("sub_3_5", 32'(result), 32'hFE);
        chk("sub_3_5_cout", 32'(cout), 32'h0);
        chk("wb_imm", 32'(wb_data), 32'h42);
        cyc();
        wb_sel = 1'b0;

        mem_addr = 8'h10; mem_wr_en = 1'b1; mem_wdata = 8'hA5; cyc();
        mem_wr_en = 1'b0; mem_rd_en = 1'b1; cyc();
        chk("rd_a5", 32'(mem_rdata), 32'hA5);
        chk("rd_a5_vld", 32'(mem_rvalid), 32'h1);
        mem_rd_en = 1'b0; cyc();
        chk("idle_vld", 32'(mem_rvalid), 32'h0);
        chk("idle_hold", 32'(mem_rdata), 32'hA5);

        mem_rd_en = 1'b1; mem_wr_en = 1'b1; mem_wdata = 8'h5A; cyc();
        chk("rbw_old", 32'(mem_rdata), 32'hA5);
        mem_wr_en = 1'b0; cyc();
        chk("rbw_new", 32'(mem_rdata), 32'h5A);
        chk("b2b_vld", 32'(mem_rvalid), 32'h1);

        cyc();
        reset = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b1; mem_wdata = 8'h77; cyc();
        chk("rst_cancel_vld", 32'(mem_rvalid), 32'h0);
        chk("rst_cancel_data", 32'(mem_rdata), 32'h0);
        reset = 1'b0; mem_wr_en = 1'b0; mem_rd_en = 1'b1; cyc();
        chk("post_rst_rd", 32'(mem_rdata), 32'h5A);
        mem_rd_en = 1'b0;

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 19) == 0);
            a_sel     = 1'($urandom);
            a_reg     = 8'($urandom);
            a_imm     = 8'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? a_reg : 8'($urandom);
            sub       = 1'($urandom);
            wb_sel    = 1'($urandom);
            mem_addr  = 8'($urandom_range(0, 15));
            mem_rd_en = 1'($urandom);
            mem_wr_en = 1'($urandom);
            mem_wdata = 8'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
